// File: rtl/aud_pkg.sv
// Shared audio-path definitions: sample/address widths and the ADC
// deserializer state encoding (also shown on the debug LEDs).
package aud_pkg;

    localparam int AUD_DATA_W  = 16;
    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_SHIFT = 2'd2,
        S_OUT   = 2'd3
    } aud_deser_state_t;

endpackage

// File: rtl/aud_adc_deser_if.sv
// Sample hand-off bus from the ADC deserializer to the SRAM writer:
// one sample plus its target word address, valid/ready handshake.
interface aud_adc_deser_if
    import aud_pkg::*;
#(
    parameter int DATA_W = AUD_DATA_W,
    parameter int ADDR_W = SRAM_ADDR_W
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic              ready;

    modport master (output valid, data, addr, input ready);
    modport slave  (input valid, data, addr, output ready);
endinterface

// File: rtl/aud_sync_edge.sv
// Two-flop synchronizer for an asynchronous codec line, with a third flop
// to produce single-cycle rise/fall pulses on the synchronized level.
module aud_sync_edge (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);
    logic [2:0] sh;

    // shift the async line through the synchronizer and edge-history flop
    always_ff @(posedge i_clk) begin
        if (i_rst) sh <= '0;
        else       sh <= {sh[1:0], i_async};
    end

    assign o_sync = sh[1];
    assign o_rise =  sh[1] & ~sh[2];
    assign o_fall = ~sh[1] &  sh[2];
endmodule

// File: rtl/aud_adc_deser.sv
// I2S ADC deserializer: captures left-channel samples from the codec
// (codec is clock master) and hands each one with its SRAM word address
// to the SRAM writer. Tracks record length, full and overrun.
module aud_adc_deser
    import aud_pkg::*;
#(
    parameter int                DATA_W   = AUD_DATA_W,
    parameter int                ADDR_W   = SRAM_ADDR_W,
    parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_pause,
    input  logic              i_stop,
    input  logic              i_aud_bclk,
    input  logic              i_aud_adclrck,
    input  logic              i_aud_adcdat,
    aud_adc_deser_if.master   sink,
    output logic [ADDR_W:0]   o_len,
    output logic              o_full,
    output logic              o_overrun,
    output logic [1:0]        o_state
);
    localparam int              CNT_W   = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(DATA_W - 1);
    localparam logic [ADDR_W:0] LEN_MAX = {1'b0, MAX_ADDR} + (ADDR_W + 1)'(1);

    aud_deser_state_t   state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               skip_q, skip_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W:0]    len_q, len_d;
    logic               full_q, full_d;
    logic               ovr_q, ovr_d;
    logic               xfer;

    logic bclk_s, bclk_rise, bclk_fall;
    logic lrck_s, lrck_rise, lrck_fall;
    logic [1:0] dat_sh;
    logic       dat_s;

    aud_sync_edge u_bclk (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_aud_bclk),
        .o_sync (bclk_s),
        .o_rise (bclk_rise),
        .o_fall (bclk_fall)
    );

    aud_sync_edge u_lrck (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_async(i_aud_adclrck),
        .o_sync (lrck_s),
        .o_rise (lrck_rise),
        .o_fall (lrck_fall)
    );

    // data line gets the same two-flop delay as bclk so a detected bclk
    // rise lines up with the bit the codec presented at that edge
    always_ff @(posedge i_clk) begin
        if (i_rst) dat_sh <= '0;
        else       dat_sh <= {dat_sh[0], i_aud_adcdat};
    end
    assign dat_s = dat_sh[1];

    // levels and the opposite edges are not needed by the capture logic
    logic unused_sync;
    assign unused_sync = &{1'b0, bclk_s, bclk_fall, lrck_s, lrck_rise};

    // state register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // next-state and datapath updates; stop overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        skip_d  = skip_q;
        shreg_d = shreg_q;
        data_d  = data_q;
        addr_d  = addr_q;
        len_d   = len_q;
        full_d  = full_q;
        ovr_d   = ovr_q;
        xfer    = (state_q == S_OUT) && sink.ready;

        if (i_stop) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_start) begin
                        addr_d  = '0;
                        len_d   = '0;
                        full_d  = 1'b0;
                        ovr_d   = 1'b0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // LRCK low marks the left word; pause only gates frame start
                    if (lrck_fall && !i_pause) begin
                        skip_d  = 1'b1;
                        cnt_d   = '0;
                        state_d = S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (bclk_rise) begin
                        // I2S puts the MSB one BCLK after the LRCK edge
                        if (skip_q) begin
                            skip_d = 1'b0;
                        end else begin
                            shreg_d = {shreg_q[DATA_W-2:0], dat_s};
                            cnt_d   = cnt_q + CNT_W'(1);
                            if (cnt_q == LAST) begin
                                data_d  = {shreg_q[DATA_W-2:0], dat_s};
                                state_d = S_OUT;
                            end
                        end
                    end
                end
                S_OUT: begin
                    if (xfer) begin
                        len_d = (len_q == LEN_MAX) ? len_q : len_q + (ADDR_W + 1)'(1);
                        if (addr_q == MAX_ADDR) begin
                            full_d  = 1'b1;
                            state_d = S_IDLE;
                        end else begin
                            addr_d  = addr_q + ADDR_W'(1);
                            state_d = S_WAIT;
                        end
                    end else if (lrck_fall) begin
                        // writer still busy when the next left word begins
                        ovr_d = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // datapath registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q   <= '0;
            skip_q  <= 1'b0;
            shreg_q <= '0;
            data_q  <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            skip_q  <= skip_d;
            shreg_q <= shreg_d;
            data_q  <= data_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            full_q  <= full_d;
            ovr_q   <= ovr_d;
        end
    end

    assign sink.valid = (state_q == S_OUT);
    assign sink.data  = data_q;
    assign sink.addr  = addr_q;
    assign o_len      = len_q;
    assign o_full     = full_q;
    assign o_overrun  = ovr_q;
    assign o_state    = state_q;
endmodule

// File: tb/tb_aud_adc_deser.sv
// Directed bench for the I2S ADC deserializer. Two instances share all
// stimulus: one with the default MAX_ADDR and one with MAX_ADDR=3.
module tb_aud_adc_deser;
    import aud_pkg::*;

    logic i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic i_rst, start, pause, stop, bclk, lrck, dat, ready;
    logic [20:0] len, len_s;
    logic full, full_s, ovr, ovr_s;
    logic [1:0] st, st_s;

    aud_adc_deser_if #(.DATA_W(16), .ADDR_W(20)) bus ();
    aud_adc_deser_if #(.DATA_W(16), .ADDR_W(20)) bus_s ();
    assign bus.ready   = ready;
    assign bus_s.ready = ready;

    aud_adc_deser #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'hFFFFF)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
        .sink(bus), .o_len(len), .o_full(full), .o_overrun(ovr), .o_state(st)
    );

    aud_adc_deser #(.DATA_W(16), .ADDR_W(20), .MAX_ADDR(20'd3)) dut_s (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(start), .i_pause(pause), .i_stop(stop),
        .i_aud_bclk(bclk), .i_aud_adclrck(lrck), .i_aud_adcdat(dat),
        .sink(bus_s), .o_len(len_s), .o_full(full_s), .o_overrun(ovr_s), .o_state(st_s)
    );

    int n_cmp = 0;
    int n_err = 0;

    // transfer logs, sampled on the falling edge
    logic [15:0] log_d[$];
    logic [19:0] log_a[$];
    logic [15:0] log_ds[$];
    logic [19:0] log_as[$];
    int vcnt = 0;

    always @(negedge i_clk) begin
        if (bus.valid && bus.ready) begin
            log_d.push_back(bus.data);
            log_a.push_back(bus.addr);
        end
        if (bus_s.valid && bus_s.ready) begin
            log_ds.push_back(bus_s.data);
            log_as.push_back(bus_s.addr);
        end
        if (bus.valid) vcnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // one BCLK period = 8 i_clk; codec changes LRCK/DAT on BCLK fall
    task automatic slot(input logic lr, input logic d);
        bclk = 1'b0; lrck = lr; dat = d;
        tick(4);
        bclk = 1'b1;
        tick(4);
    endtask

    // 20 BCLKs per half: I2S skip slot, 16 data bits MSB first, 3 pad
    task automatic half(input logic lr, input logic [15:0] w);
        slot(lr, 1'b0);
        for (int i = 15; i >= 0; i--) slot(lr, w[i]);
        for (int i = 0; i < 3; i++) slot(lr, 1'b0);
    endtask

    task automatic frame(input logic [15:0] l, input logic [15:0] r);
        half(1'b0, l);
        half(1'b1, r);
    endtask

    task automatic restart();
        stop = 1'b1; tick(1); stop = 1'b0;
        start = 1'b1; tick(1); start = 1'b0;
        tick(1);
        log_d.delete(); log_a.delete(); log_ds.delete(); log_as.delete();
        vcnt = 0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; start = 0; pause = 0; stop = 0; bclk = 0; lrck = 1; dat = 0; ready = 0;
        tick(3);
        @(negedge i_clk);
        n_cmp++; if (st !== 2'd0)      begin n_err++; $display("FAIL reset_state: got %0d want 0", st); end
        n_cmp++; if (bus.valid !== 0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", bus.valid); end
        n_cmp++; if (bus.data !== 0 || bus.addr !== 0) begin n_err++; $display("FAIL reset_data_addr: got %h/%h want 0/0", bus.data, bus.addr); end
        n_cmp++; if (len !== 0 || full !== 0 || ovr !== 0) begin n_err++; $display("FAIL reset_status: got len=%0d full=%b ovr=%b want 0/0/0", len, full, ovr); end
        tick(1);
        i_rst = 1'b0;
        tick(2);
    endtask

    task automatic test_basic();
        ready = 1'b1;
        start = 1'b1; tick(1); start = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (st !== 2'd1) begin n_err++; $display("FAIL start_to_wait: got %0d want 1", st); end
        log_d.delete(); log_a.delete(); log_ds.delete(); log_as.delete(); vcnt = 0;
        frame(16'hA5C3, 16'hFFFF);
        tick(4);
        @(negedge i_clk);
        n_cmp++; if (log_d.size() !== 1) begin n_err++; $display("FAIL basic_count: got %0d want 1", log_d.size()); end
        else begin
            n_cmp++; if (log_d[0] !== 16'hA5C3 || log_a[0] !== 20'd0) begin n_err++; $display("FAIL basic_word: got %h@%0d want a5c3@0", log_d[0], log_a[0]); end
        end
        n_cmp++; if (len !== 21'd1 || bus.addr !== 20'd1) begin n_err++; $display("FAIL basic_len_addr: got %0d/%0d want 1/1", len, bus.addr); end
        n_cmp++; if (vcnt !== 1) begin n_err++; $display("FAIL basic_valid_cycles: got %0d want 1", vcnt); end
        n_cmp++; if (st !== 2'd1) begin n_err++; $display("FAIL basic_state: got %0d want 1", st); end
        tick(1);
    endtask

    task automatic test_overrun();
        restart();
        ready = 1'b0;
        frame(16'h1111, 16'h0000);
        frame(16'h2222, 16'h0000);
        @(negedge i_clk);
        n_cmp++; if (bus.valid !== 1 || bus.data !== 16'h1111) begin n_err++; $display("FAIL ovr_hold: got v=%b d=%h want 1/1111", bus.valid, bus.data); end
        n_cmp++; if (ovr !== 1) begin n_err++; $display("FAIL ovr_flag: got %b want 1", ovr); end
        tick(1);
        ready = 1'b1;
        tick(4);
        @(negedge i_clk);
        n_cmp++; if (log_d.size() !== 1) begin n_err++; $display("FAIL ovr_count: got %0d want 1", log_d.size()); end
        else begin
            n_cmp++; if (log_d[0] !== 16'h1111 || log_a[0] !== 20'd0) begin n_err++; $display("FAIL ovr_word: got %h@%0d want 1111@0", log_d[0], log_a[0]); end
        end
        n_cmp++; if (len !== 21'd1 || ovr !== 1) begin n_err++; $display("FAIL ovr_after: got len=%0d ovr=%b want 1/1", len, ovr); end
        tick(1);
    endtask

    task automatic test_full();
        logic [15:0] words [5];
        words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044, 16'h0055};
        restart();
        ready = 1'b1;
        for (int i = 0; i < 4; i++) frame(words[i], 16'hFFFF);
        @(negedge i_clk);
        n_cmp++; if (log_ds.size() !== 4) begin n_err++; $display("FAIL full_count: got %0d want 4", log_ds.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                n_cmp++;
                if (log_ds[i] !== words[i] || log_as[i] !== 20'(i)) begin
                    n_err++; $display("FAIL full_word%0d: got %h@%0d want %h@%0d", i, log_ds[i], log_as[i], words[i], i);
                end
            end
        end
        n_cmp++; if (full_s !== 1 || st_s !== 2'd0 || len_s !== 21'd4) begin n_err++; $display("FAIL full_status: got full=%b st=%0d len=%0d want 1/0/4", full_s, st_s, len_s); end
        tick(1);
        frame(words[4], 16'hFFFF);
        @(negedge i_clk);
        n_cmp++; if (log_ds.size() !== 4 || len_s !== 21'd4) begin n_err++; $display("FAIL full_ignore: got n=%0d len=%0d want 4/4", log_ds.size(), len_s); end
        n_cmp++; if (len !== 21'd5 || full !== 0 || bus.addr !== 20'd5) begin n_err++; $display("FAIL big_no_full: got len=%0d full=%b addr=%0d want 5/0/5", len, full, bus.addr); end
        tick(1);
    endtask

    task automatic test_stop_midshift();
        logic [15:0] w;
        w = 16'hC3F0;
        restart();
        ready = 1'b1;
        frame(16'h1357, 16'h0000);
        vcnt = 0;
        slot(1'b0, 1'b0);
        for (int i = 15; i >= 8; i--) slot(1'b0, w[i]);
        stop = 1'b1;
        @(posedge i_clk); #1 stop = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (st !== 2'd0 || bus.valid !== 0) begin n_err++; $display("FAIL stop_state: got st=%0d v=%b want 0/0", st, bus.valid); end
        for (int i = 7; i >= 0; i--) slot(1'b0, w[i]);
        for (int i = 0; i < 3; i++) slot(1'b0, 1'b0);
        half(1'b1, 16'h0000);
        @(negedge i_clk);
        n_cmp++; if (vcnt !== 0 || len !== 21'd1) begin n_err++; $display("FAIL stop_discard: got vcycles=%0d len=%0d want 0/1", vcnt, len); end
        tick(1);
        start = 1'b1; tick(1); start = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (len !== 0 || bus.addr !== 0 || st !== 2'd1) begin n_err++; $display("FAIL stop_restart: got len=%0d addr=%0d st=%0d want 0/0/1", len, bus.addr, st); end
        tick(1);
    endtask

    task automatic test_pause();
        restart();
        ready = 1'b0;
        pause = 1'b0;
        frame(16'h0F0F, 16'h0000);
        pause = 1'b1;
        tick(2);
        @(negedge i_clk);
        n_cmp++; if (bus.valid !== 1 || bus.data !== 16'h0F0F) begin n_err++; $display("FAIL pause_hold: got v=%b d=%h want 1/0f0f", bus.valid, bus.data); end
        tick(1);
        ready = 1'b1;
        tick(2);
        frame(16'hBEEF, 16'h0000);
        frame(16'hCAFE, 16'h0000);
        @(negedge i_clk);
        n_cmp++; if (log_d.size() !== 1 || ovr !== 0 || st !== 2'd1) begin n_err++; $display("FAIL pause_skip: got n=%0d ovr=%b st=%0d want 1/0/1", log_d.size(), ovr, st); end
        tick(1);
        pause = 1'b0;
        frame(16'h1234, 16'h0000);
        @(negedge i_clk);
        n_cmp++; if (log_d.size() !== 2) begin n_err++; $display("FAIL pause_count: got %0d want 2", log_d.size()); end
        else begin
            n_cmp++; if (log_d[0] !== 16'h0F0F || log_d[1] !== 16'h1234 || log_a[1] !== 20'd1) begin n_err++; $display("FAIL pause_words: got %h,%h@%0d want 0f0f,1234@1", log_d[0], log_d[1], log_a[1]); end
        end
        n_cmp++; if (len !== 21'd2) begin n_err++; $display("FAIL pause_len: got %0d want 2", len); end
        tick(1);
    endtask

    task automatic test_reset_busy();
        ready = 1'b0;
        frame(16'h5A5A, 16'h0000);
        @(negedge i_clk);
        n_cmp++; if (bus.valid !== 1 || bus.data !== 16'h5A5A) begin n_err++; $display("FAIL rst_pre: got v=%b d=%h want 1/5a5a", bus.valid, bus.data); end
        tick(1);
        i_rst = 1'b1;
        @(posedge i_clk); #1 i_rst = 1'b0;
        @(negedge i_clk);
        n_cmp++; if (bus.valid !== 0 || st !== 2'd0) begin n_err++; $display("FAIL rst_busy_state: got v=%b st=%0d want 0/0", bus.valid, st); end
        n_cmp++; if (bus.data !== 0 || bus.addr !== 0 || len !== 0) begin n_err++; $display("FAIL rst_busy_data: got d=%h a=%0d len=%0d want 0/0/0", bus.data, bus.addr, len); end
        n_cmp++; if (full !== 0 || ovr !== 0 || st_s !== 2'd0 || bus_s.valid !== 0) begin n_err++; $display("FAIL rst_busy_flags: got full=%b ovr=%b st_s=%0d v_s=%b want 0/0/0/0", full, ovr, st_s, bus_s.valid); end
        tick(1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full();
        test_stop_midshift();
        test_pause();
        test_reset_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
